// File: rtl/ddr_app_cmd_bridge_pkg.sv
// ddr_app_cmd_bridge_pkg: app-port command codes and credit counter sizing
package ddr_app_cmd_bridge_pkg;
  localparam logic [2:0] DDR_CMD_WRITE = 3'b000;
  localparam logic [2:0] DDR_CMD_READ = 3'b001;
  function automatic int credit_width(input int max_outstanding);
    return $clog2(max_outstanding) + 1;
  endfunction
endpackage

// File: rtl/ddr_app_cmd_bridge_sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO; pushes while full are dropped
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic do_push, do_pop;
  always_comb begin
    empty = wp_q == rp_q;
    full = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    do_push = push & ~full;
    do_pop = pop & ~empty;
    wp_d = wp_q + (AW+1)'(do_push);
    rp_d = rp_q + (AW+1)'(do_pop);
    dout = mem_q[rp_q[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
    if (do_push) mem_q[wp_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/ddr_app_cmd_bridge.sv
// ddr_app_cmd_bridge: ram_cmd to DDR3 app-port bridge with pipelined, credit-limited reads
module ddr_app_cmd_bridge
  import ddr_app_cmd_bridge_pkg::*;
#(
  parameter int DATA_WIDTH      = 128,
  parameter int ADDR_WIDTH      = 32,
  parameter int STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int ID_WIDTH        = 8,
  parameter int APP_ADDR_WIDTH  = 29,
  parameter int ADDR_LSB        = 0,
  parameter int MAX_OUTSTANDING = 4,
  parameter int WR_WAIT_RD      = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ID_WIDTH-1:0]       ram_cmd_id,
  input  logic [ADDR_WIDTH-1:0]     ram_cmd_addr,
  input  logic [DATA_WIDTH-1:0]     ram_cmd_wr_data,
  input  logic [STRB_WIDTH-1:0]     ram_cmd_wr_strb,
  input  logic                      ram_cmd_wr_en,
  input  logic                      ram_cmd_rd_en,
  input  logic                      ram_cmd_last,
  output logic                      ram_cmd_ready,
  output logic [ID_WIDTH-1:0]       ram_rd_resp_id,
  output logic [DATA_WIDTH-1:0]     ram_rd_resp_data,
  output logic                      ram_rd_resp_last,
  output logic                      ram_rd_resp_valid,
  input  logic                      ram_rd_resp_ready,
  input  logic                      init_calib_complete,
  input  logic                      app_cmd_ready,
  output logic                      app_cmd_en,
  output logic [2:0]                app_cmd,
  output logic [APP_ADDR_WIDTH-1:0] app_addr,
  input  logic                      app_wdf_rdy,
  output logic                      app_wdf_wren,
  output logic                      app_wdf_end,
  output logic [DATA_WIDTH-1:0]     app_wdf_data,
  output logic [STRB_WIDTH-1:0]     app_wdf_mask,
  input  logic [DATA_WIDTH-1:0]     app_rd_data,
  input  logic                      app_rd_data_valid,
  output logic                      err_rd_overflow,
  output logic                      err_rd_unexpected
);
  localparam int CW = credit_width(MAX_OUTSTANDING);
  typedef struct packed {
    logic [ID_WIDTH-1:0]       id;
    logic [APP_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]     data;
    logic [STRB_WIDTH-1:0]     strb;
    logic                      rd;
    logic                      last;
  } cmd_t;
  cmd_t cmd_q, cmd_d;
  logic cmd_v_q, cmd_v_d, err_ovf_q, err_ovf_d, err_unx_q, err_unx_d;
  logic [CW-1:0] credits_q, credits_d, resp_cnt_q, resp_cnt_d;
  logic issue_rd, issue_wr, issue, accept, rd_push, rsp_pop, unused_addr;
  logic tag_full, tag_empty, resp_full, resp_empty;
  logic [ID_WIDTH:0] tag_dout;
  logic [DATA_WIDTH-1:0] resp_dout;
  always_comb begin
    unused_addr = ^ram_cmd_addr;
    issue_rd = ~rst & cmd_v_q & cmd_q.rd & app_cmd_ready & ~tag_full & (credits_q < CW'(MAX_OUTSTANDING));
    issue_wr = ~rst & cmd_v_q & ~cmd_q.rd & app_cmd_ready & app_wdf_rdy & ((WR_WAIT_RD == 0) | (credits_q == '0));
    issue = issue_rd | issue_wr;
    ram_cmd_ready = ~rst & init_calib_complete & (~cmd_v_q | issue);
    accept = (ram_cmd_wr_en | ram_cmd_rd_en) & ram_cmd_ready;
    cmd_v_d = accept | (cmd_v_q & ~issue);
    cmd_d = accept ? cmd_t'{id: ram_cmd_id, addr: ram_cmd_addr[ADDR_LSB +: APP_ADDR_WIDTH],
                            data: ram_cmd_wr_data, strb: ram_cmd_wr_strb, rd: ram_cmd_rd_en,
                            last: ram_cmd_last} : cmd_q;
    app_cmd_en = issue;
    app_cmd = issue_rd ? DDR_CMD_READ : DDR_CMD_WRITE;
    app_addr = issue ? cmd_q.addr : '0;
    app_wdf_wren = issue_wr;
    app_wdf_end = issue_wr;
    app_wdf_data = issue_wr ? cmd_q.data : '0;
    app_wdf_mask = issue_wr ? ~cmd_q.strb : '0;
    // data is only kept while some issued read still lacks its data
    rd_push = app_rd_data_valid & ~resp_full & (resp_cnt_q != credits_q);
    ram_rd_resp_valid = ~rst & ~resp_empty & ~tag_empty;
    rsp_pop = ram_rd_resp_valid & ram_rd_resp_ready;
    ram_rd_resp_id = ram_rd_resp_valid ? tag_dout[ID_WIDTH:1] : '0;
    ram_rd_resp_last = ram_rd_resp_valid & tag_dout[0];
    ram_rd_resp_data = ram_rd_resp_valid ? resp_dout : '0;
    credits_d = credits_q + CW'(issue_rd) - CW'(rsp_pop);
    resp_cnt_d = resp_cnt_q + CW'(rd_push) - CW'(rsp_pop);
    err_ovf_d = err_ovf_q | (app_rd_data_valid & resp_full);
    err_unx_d = err_unx_q | (app_rd_data_valid & (resp_cnt_q == credits_q));
    err_rd_overflow = err_ovf_q;
    err_rd_unexpected = err_unx_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q <= '0;
      cmd_v_q <= 1'b0;
      credits_q <= '0;
      resp_cnt_q <= '0;
      err_ovf_q <= 1'b0;
      err_unx_q <= 1'b0;
    end else begin
      cmd_q <= cmd_d;
      cmd_v_q <= cmd_v_d;
      credits_q <= credits_d;
      resp_cnt_q <= resp_cnt_d;
      err_ovf_q <= err_ovf_d;
      err_unx_q <= err_unx_d;
    end
  end
  sync_fifo_fwft #(.WIDTH(ID_WIDTH + 1), .DEPTH(MAX_OUTSTANDING)) tag_fifo (
    .clk(clk), .rst(rst), .push(issue_rd), .pop(rsp_pop), .din({cmd_q.id, cmd_q.last}),
    .full(tag_full), .empty(tag_empty), .dout(tag_dout)
  );
  sync_fifo_fwft #(.WIDTH(DATA_WIDTH), .DEPTH(MAX_OUTSTANDING)) resp_fifo (
    .clk(clk), .rst(rst), .push(rd_push), .pop(rsp_pop), .din(app_rd_data),
    .full(resp_full), .empty(resp_empty), .dout(resp_dout)
  );
endmodule
